// File: rtl/hw_timer_avalon_slave.sv
// Avalon-MM interval timer: 32-bit down-counter with prescaler, one-shot or
// continuous reload, count snapshot and a level interrupt.
module hw_timer_avalon_slave #(
  parameter int          PRESCALE_W   = 16,
  parameter logic [31:0] RESET_PERIOD = 32'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq
);

  logic                  run_r;
  logic                  cont_r;
  logic                  irq_en_r;
  logic                  to_r;
  logic [31:0]           count_r;
  logic [31:0]           period_r;
  logic [31:0]           snap_r;
  logic [PRESCALE_W-1:0] prescale_r;
  logic [PRESCALE_W-1:0] pcnt_r;

  logic                  wr_ctrl_s;
  logic                  wr_status_s;
  logic                  wr_period_s;
  logic                  wr_prescale_s;
  logic                  wr_snap_s;
  logic                  start_s;
  logic                  stop_s;
  logic                  tick_s;
  logic                  expire_s;
  logic                  to_clr_s;
  logic [31:0]           prescale_ext_s;
  logic [31:0]           rd_mux_s;

  // Write decode and prescaler tick; a START or STOP write overrides counting
  always_comb begin
    wr_ctrl_s     = write && (address == 3'd0);
    wr_status_s   = write && (address == 3'd1);
    wr_period_s   = write && (address == 3'd2);
    wr_prescale_s = write && (address == 3'd4);
    wr_snap_s     = write && (address == 3'd5);
    start_s       = wr_ctrl_s && writedata[3];
    stop_s        = wr_ctrl_s && writedata[4];
    to_clr_s      = wr_status_s && writedata[0];
    // >= keeps the prescaler from running to wrap if PRESCALE shrinks mid-run
    tick_s        = run_r && (pcnt_r >= prescale_r) && !start_s && !stop_s;
    expire_s      = tick_s && (count_r == 32'd0);
  end

  // Read data selection from current register state (pre-write values)
  always_comb begin
    prescale_ext_s                   = 32'd0;
    prescale_ext_s[PRESCALE_W-1:0]   = prescale_r;
    case (address)
      3'd0:    rd_mux_s = {27'd0, 2'b00, irq_en_r, cont_r, run_r};
      3'd1:    rd_mux_s = {30'd0, run_r, to_r};
      3'd2:    rd_mux_s = period_r;
      3'd3:    rd_mux_s = count_r;
      3'd4:    rd_mux_s = prescale_ext_s;
      3'd5:    rd_mux_s = snap_r;
      default: rd_mux_s = 32'd0;
    endcase
  end

  // Register file, run control, prescaler and down-counter
  always_ff @(posedge clk) begin
    if (reset) begin
      readdata   <= 32'd0;
      run_r      <= 1'b0;
      cont_r     <= 1'b0;
      irq_en_r   <= 1'b0;
      to_r       <= 1'b0;
      count_r    <= 32'd0;
      period_r   <= RESET_PERIOD;
      snap_r     <= 32'd0;
      prescale_r <= '0;
      pcnt_r     <= '0;
    end else begin
      if (read) begin
        readdata <= rd_mux_s;
      end
      if (wr_ctrl_s) begin
        cont_r   <= writedata[1];
        irq_en_r <= writedata[2];
      end
      if (wr_period_s) begin
        period_r <= writedata;
      end
      if (wr_prescale_s) begin
        prescale_r <= writedata[PRESCALE_W-1:0];
      end
      if (wr_snap_s) begin
        snap_r <= count_r;
      end
      // Expiry has priority over a simultaneous write-1-to-clear
      if (expire_s) begin
        to_r <= 1'b1;
      end else if (to_clr_s) begin
        to_r <= 1'b0;
      end
      if (stop_s) begin
        run_r <= 1'b0;
      end else if (start_s) begin
        run_r   <= 1'b1;
        count_r <= period_r;
        pcnt_r  <= '0;
      end else if (run_r) begin
        if (tick_s) begin
          pcnt_r <= '0;
          if (count_r != 32'd0) begin
            count_r <= count_r - 32'd1;
          end else if (cont_r) begin
            count_r <= period_r;
          end else begin
            run_r <= 1'b0;
          end
        end else begin
          pcnt_r <= pcnt_r + PRESCALE_W'(1);
        end
      end
    end
  end

  assign irq = to_r & irq_en_r;

endmodule
